// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and grant encoding for the VGA framebuffer
//                arbiter slice.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 400;
  localparam int FB_ADDR_W = 18;
  localparam int PIX_W     = 8;

  // Which requester owns the RAM port in the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_W0   = 2'd2,
    GNT_W1   = 2'd3
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/vga_vram_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter with a global enable.
//                Grants are combinational; the last-grant pointer moves only
//                when a grant is actually issued.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic r_last;

  // Grant a lone requester directly; on a tie grant the one not served last
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        if (r_last) o_gnt0 = 1'b1;
        else        o_gnt1 = 1'b1;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  // Track who was served last; idle and disabled cycles leave it untouched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (o_gnt0) begin
      r_last <= 1'b0;
    end else if (o_gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vram_arbiter
//  Description : Shares a single-port framebuffer RAM between display scanout
//                (absolute priority) and two round-robin writers, and manages
//                front/back double buffering with swaps deferred to animate.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_animate,
  input  logic              i_swap_req,
  output logic              o_swap_pending,
  output logic              o_front,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_w0_valid,
  input  logic              i_w1_valid,
  output logic              o_w0_ready,
  output logic              o_w1_ready,
  input  logic [ADDR_W-1:0] i_w0_addr,
  input  logic [ADDR_W-1:0] i_w1_addr,
  input  logic [DATA_W-1:0] i_w0_data,
  input  logic [DATA_W-1:0] i_w1_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W:0]   o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_swap_now;
  grant_t            w_grant;

  logic              r_front;
  logic              r_pending;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W:0]   r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_ret;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;

  // Writers only compete when the display leaves the port free
  rr_arbiter2 u_rr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (!i_disp_req),
    .i_req0 (i_w0_valid),
    .i_req1 (i_w1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign o_w0_ready = w_gnt0;
  assign o_w1_ready = w_gnt1;

  // Collapse the individual grants into a single owner for this cycle
  always_comb begin
    w_grant = GNT_NONE;
    if (i_disp_req)  w_grant = GNT_DISP;
    else if (w_gnt0) w_grant = GNT_W0;
    else if (w_gnt1) w_grant = GNT_W1;
  end

  // A same-cycle request counts, so a request on the animate tick swaps at once
  assign w_swap_now = i_animate && (r_pending || i_swap_req);

  // Front-buffer select and deferred swap request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_swap_now) begin
      r_front   <= ~r_front;
      r_pending <= 1'b0;
    end else if (i_swap_req) begin
      r_pending <= 1'b1;
    end
  end

  // Register the granted access toward the RAM; buffer bit uses pre-swap front
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (w_grant)
        GNT_DISP: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= {r_front, i_disp_addr};
        end
        GNT_W0: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= {~r_front, i_w0_addr};
          r_mem_wdata <= i_w0_data;
        end
        GNT_W1: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= {~r_front, i_w1_addr};
          r_mem_wdata <= i_w1_data;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read-return pipeline: RAM data arrives one cycle after a read is issued
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ret     <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_rd_ret     <= r_mem_en && !r_mem_we;
      r_disp_valid <= r_rd_ret;
      if (r_rd_ret) r_disp_data <= i_mem_rdata;
    end
  end

  assign o_front        = r_front;
  assign o_swap_pending = r_pending;
  assign o_mem_en       = r_mem_en;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_disp_valid   = r_disp_valid;
  assign o_disp_data    = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_vram_arbiter
//  Description : Scoreboard bench for vga_vram_arbiter with a cycle-level
//                reference model and a behavioural RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_vram_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          animate, swap_req, swap_pending, front;
  logic          disp_req, disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          w0v, w1v, w0r, w1r;
  logic [AW-1:0] w0a, w1a;
  logic [DW-1:0] w0d, w1d;
  logic          mem_en, mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_animate(animate), .i_swap_req(swap_req),
    .o_swap_pending(swap_pending), .o_front(front),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(disp_valid), .o_disp_data(disp_data),
    .i_w0_valid(w0v), .i_w1_valid(w1v), .o_w0_ready(w0r), .o_w1_ready(w1r),
    .i_w0_addr(w0a), .i_w1_addr(w1a), .i_w0_data(w0d), .i_w1_data(w1d),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM content is a fixed function of the full address, buffer bit included
  function automatic logic [DW-1:0] ram_f(input logic [AW:0] a);
    return a[7:0] ^ a[15:8] ^ {a[18], a[17:16], 5'h05};
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram_f(mem_addr);
  end

  typedef struct {
    logic          we;
    logic [AW:0]   addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t           opq[$];
  logic [DW-1:0] rdq[$];

  // Reference model state
  logic m_front, m_pend, m_last;
  logic g0, g1, held0, held1;

  // Monitor: compares every RAM access and every display return in order
  always @(negedge clk) begin
    if (mem_en) begin
      if (opq.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 32'd0);
      else begin
        op_t op;
        op = opq.pop_front();
        chk("mem_we", 32'(mem_we), 32'(op.we));
        chk("mem_addr", 32'(mem_addr), 32'(op.addr));
        if (op.we) chk("mem_wdata", 32'(mem_wdata), 32'(op.wdata));
      end
    end
    if (disp_valid) begin
      if (rdq.size() == 0) chk("disp_valid_unexpected", 32'(disp_valid), 32'd0);
      else chk("disp_data", 32'(disp_data), 32'(rdq.pop_front()));
    end
  end

  // One clock: check combinational/state outputs, record expectations, advance
  task automatic step();
    logic e0, e1;
    @(negedge clk); #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!disp_req) begin
      if (w0v && w1v) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = w0v;
        e1 = w1v;
      end
    end
    chk("w0_ready", 32'(w0r), 32'(e0));
    chk("w1_ready", 32'(w1r), 32'(e1));
    chk("front", 32'(front), 32'(m_front));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    g0 = e0;
    g1 = e1;
    if (rst) begin
      m_front = 1'b0;
      m_pend  = 1'b0;
      m_last  = 1'b1;
    end else begin
      if (disp_req) begin
        opq.push_back('{1'b0, {m_front, disp_addr}, 8'h00});
        rdq.push_back(ram_f({m_front, disp_addr}));
      end else if (e0) begin
        opq.push_back('{1'b1, {~m_front, w0a}, w0d});
        m_last = 1'b0;
      end else if (e1) begin
        opq.push_back('{1'b1, {~m_front, w1a}, w1d});
        m_last = 1'b1;
      end
      if (animate && (m_pend || swap_req)) begin
        m_front = ~m_front;
        m_pend  = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      opq.delete();
      rdq.delete();
    end
  endtask

  task automatic idle();
    disp_req = 0; w0v = 0; w1v = 0; swap_req = 0; animate = 0;
  endtask

  task automatic drive_random();
    disp_req  = ($urandom % 4) == 0;
    disp_addr = AW'($urandom);
    swap_req  = ($urandom % 16) == 0;
    animate   = ($urandom % 24) == 0;
    if (!held0) begin
      w0v = ($urandom % 2) == 0;
      w0a = AW'($urandom);
      w0d = DW'($urandom);
    end
    if (!held1) begin
      w1v = ($urandom % 2) == 0;
      w1a = AW'($urandom);
      w1d = DW'($urandom);
    end
  endtask

  initial begin
    rst = 1; idle();
    disp_addr = '0; w0a = '0; w1a = '0; w0d = '0; w1d = '0;
    m_front = 0; m_pend = 0; m_last = 1; held0 = 0; held1 = 0;
    @(posedge clk); #1;
    step(); step();

    // Reset values
    chk("rst_front", 32'(front), 32'd0);
    chk("rst_pending", 32'(swap_pending), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    rst = 0;

    // Single writer
    w0v = 1; w0a = 18'd5; w0d = 8'h3C; step();
    idle(); step();

    // Both writers contending, then a display read cutting in
    w0v = 1; w1v = 1; w0a = 18'd10; w1a = 18'd20; w0d = 8'h11; w1d = 8'h22;
    repeat (4) step();
    disp_req = 1; disp_addr = 18'd100; step();
    disp_req = 0; repeat (3) step();
    idle(); repeat (4) step();

    // Deferred swap, then writes and reads on the new mapping
    swap_req = 1; step();
    swap_req = 0; repeat (3) step();
    animate = 1; step();
    animate = 0; w0v = 1; w0a = 18'd7; w0d = 8'h77; step();
    idle(); disp_req = 1; disp_addr = 18'd7; step();
    idle(); repeat (4) step();

    // Immediate swap, redundant request while pending, one swap per animate
    swap_req = 1; animate = 1; step();
    animate = 0; step();
    step();
    swap_req = 0; animate = 1; step();
    step();
    animate = 0; repeat (2) step();

    // Randomised traffic
    held0 = 0; held1 = 0; idle();
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
      held0 = w0v && !g0;
      held1 = w1v && !g1;
    end
    idle(); repeat (5) step();

    // Reads in flight when reset hits are dropped
    for (int i = 0; i < 3; i++) begin
      disp_req = 1; disp_addr = 18'(300 + i); step();
    end
    idle(); rst = 1; step();
    rst = 0;
    chk("post_rst_front", 32'(front), 32'd0);
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);
    chk("post_rst_disp_valid", 32'(disp_valid), 32'd0);
    repeat (6) step();

    chk("opq_drained", 32'(opq.size()), 32'd0);
    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
